output_accum_writer: RTL and testbench

//  Write-back end of the output-memory interface. Collects psum rows from the systolic array and

---
 rtl/output_accum_writer.sv | 185 ++++++++++++++++++
 tb/tb_output_accum_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_accum_writer.sv
// output_accum_writer: write-back end of the output-memory path.
// Psum rows from the systolic array go into a small skid FIFO. They are then
// written to output SRAM in one of two ways:
//  - overwrite on the first K tile;
//  - read-modify-write accumulate on later tiles.
// Optional build macro OUTPUT_SAT_EN: the accumulate add saturates per lane
// instead of wrapping.

// Per-lane accumulate adder (two's complement, wrap or signed saturate).
module output_accum_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
`ifdef OUTPUT_SAT_EN
  logic [W:0] sum_x;
  assign sum_x = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  // Clamp when the sign-extended carry disagrees with the result sign.
  always_comb begin
    sum_o = sum_x[W-1:0];
    if (sum_x[W] != sum_x[W-1])
      sum_o = sum_x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign sum_o = a_i + b_i;
`endif
endmodule

module output_accum_writer #(
  parameter int MAC_COL         = 16,
  parameter int OUTPUT_BITWIDTH = 32,
  parameter int OUTPUT_ADDR_BIT = 10,
  parameter int OUTPUT_COL      = 196,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 tile_start_in,
  input  logic                                 tile_first_in,
  input  logic [OUTPUT_ADDR_BIT-1:0]           tile_base_in,
  input  logic                                 psum_valid_in,
  input  logic [MAC_COL*OUTPUT_BITWIDTH-1:0]   psum_in,
  output logic                                 psum_ready_out,
  input  logic                                 mem_ready_in,
  input  logic [MAC_COL*OUTPUT_BITWIDTH-1:0]   mem_rdata_in,
  output logic [OUTPUT_ADDR_BIT-1:0]           mem_addr_out,
  output logic                                 mem_read_en_out,
  output logic                                 mem_write_en_out,
  output logic [MAC_COL*OUTPUT_BITWIDTH-1:0]   mem_wdata_out,
  output logic                                 busy_out,
  output logic                                 tile_done_out,
  output logic                                 overflow_err_out
);
  localparam int OBW   = OUTPUT_BITWIDTH;
  localparam int IDX_W = $clog2(OUTPUT_COL + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] NROWS_C = IDX_W'(OUTPUT_COL);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(OUTPUT_COL - 1);

  typedef logic [MAC_COL-1:0][OBW-1:0] row_t;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_DONE} state_t;

  state_t                     state_q;
  logic                       first_q;
  logic [OUTPUT_ADDR_BIT-1:0] base_q;
  logic [IDX_W-1:0]           idx_q, rows_in_q, rows_in_d;
  row_t                       rdata_q;
  logic                       ready_q, ready_d, busy_q, done_q, ovf_q;

  row_t                       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       push, pop, empty, last;
  logic                       rd_req, wr_req, rd_acc, wr_acc, active_d;
  logic [OUTPUT_ADDR_BIT-1:0] req_addr;
  row_t                       head, sum_row;

  assign push     = psum_valid_in && ready_q;
  assign empty    = (cnt_q == '0);
  assign head     = fifo_q[rptr_q];
  assign last     = (idx_q == LAST_C);
  // A request is only raised once the row it belongs to is in the FIFO.
  assign rd_req   = (state_q == S_RD) && !empty;
  assign wr_req   = (state_q == S_WR) && !empty;
  assign rd_acc   = rd_req && mem_ready_in;
  assign wr_acc   = wr_req && mem_ready_in;
  assign pop      = wr_acc;
  assign req_addr = base_q + OUTPUT_ADDR_BIT'(idx_q);

  // Lane adders: stored partial sum plus incoming row.
  for (genvar l = 0; l < MAC_COL; l++) begin : g_lane
    output_accum_lane #(.W(OBW)) u_lane (
      .a_i   (rdata_q[l]),
      .b_i   (head[l]),
      .sum_o (sum_row[l])
    );
  end

  // Next FIFO occupancy / row count and the registered ready it implies.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rows_in_d = (state_q == S_IDLE) ? '0 : rows_in_q + IDX_W'(push);
    active_d  = ((state_q == S_IDLE) && tile_start_in) ||
                (((state_q == S_WR) || (state_q == S_RD) || (state_q == S_WAIT)) &&
                 !(wr_acc && last));
    ready_d   = active_d && (cnt_d < DEPTH_C) && (rows_in_d < NROWS_C);
  end

  // Skid FIFO: storage plus pointers; pop happens on an accepted write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= row_t'(psum_in);
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Pass control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      first_q   <= 1'b0;
      base_q    <= '0;
      idx_q     <= '0;
      rows_in_q <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rows_in_q <= rows_in_d;
      ready_q   <= ready_d;
      if (psum_valid_in && !ready_q) ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: if (tile_start_in) begin
          first_q <= tile_first_in;
          base_q  <= tile_base_in;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= tile_first_in ? S_WR : S_RD;
        end
        S_RD:   if (rd_acc) state_q <= S_WAIT;
        S_WAIT: begin
          rdata_q <= row_t'(mem_rdata_in);
          state_q <= S_WR;
        end
        S_WR:   if (wr_acc) begin
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= first_q ? S_WR : S_RD;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign psum_ready_out   = ready_q;
  assign busy_out         = busy_q;
  assign tile_done_out    = done_q;
  assign overflow_err_out = ovf_q;
  assign mem_read_en_out  = rd_req;
  assign mem_write_en_out = wr_req;
  assign mem_addr_out     = (rd_req || wr_req) ? req_addr : '0;
  assign mem_wdata_out    = wr_req ? (first_q ? head : sum_row) : '0;
endmodule

// File: tb/tb_output_accum_writer.sv
// Randomized bench for output_accum_writer. A bench-owned SRAM array answers
// read and write requests. Expected writes are derived from the pushed rows
// using plain lane arithmetic.
module tb_output_accum_writer;
  localparam int LANES = 16;
  localparam int OBW   = 32;
  localparam int AW    = 10;
  localparam int ROWS  = 196;
  localparam int RW    = LANES * OBW;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tile_start_in, tile_first_in;
  logic [AW-1:0] tile_base_in;
  logic          psum_valid_in;
  logic [RW-1:0] psum_in;
  logic          psum_ready_out;
  logic          mem_ready_in;
  logic [RW-1:0] mem_rdata_in;
  logic [AW-1:0] mem_addr_out;
  logic          mem_read_en_out, mem_write_en_out;
  logic [RW-1:0] mem_wdata_out;
  logic          busy_out, tile_done_out, overflow_err_out;

  output_accum_writer dut (
    .clk(clk), .rstn(rstn),
    .tile_start_in(tile_start_in), .tile_first_in(tile_first_in), .tile_base_in(tile_base_in),
    .psum_valid_in(psum_valid_in), .psum_in(psum_in), .psum_ready_out(psum_ready_out),
    .mem_ready_in(mem_ready_in), .mem_rdata_in(mem_rdata_in), .mem_addr_out(mem_addr_out),
    .mem_read_en_out(mem_read_en_out), .mem_write_en_out(mem_write_en_out),
    .mem_wdata_out(mem_wdata_out), .busy_out(busy_out), .tile_done_out(tile_done_out),
    .overflow_err_out(overflow_err_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; } exp_t;

  logic [RW-1:0] mem  [MEMSZ];
  logic [RW-1:0] rows [ROWS];
  exp_t          exp_q[$];
  int            n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [RW-1:0] fill(input logic [OBW-1:0] v);
    logic [RW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*OBW +: OBW] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*OBW +: OBW] = $urandom;
    return r;
  endfunction

  // Signed lane-wise sum: wraps mod 2^32, or clamps to the int32 range.
  function automatic logic [RW-1:0] add_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] r;
    longint s;
    for (int l = 0; l < LANES; l++) begin
      s = longint'($signed(a[l*OBW +: OBW])) + longint'($signed(b[l*OBW +: OBW]));
`ifdef OUTPUT_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      r[l*OBW +: OBW] = s[OBW-1:0];
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},   RW'(mem_read_en_out), '0);
    chk({tag, "_wr"},   RW'(mem_write_en_out), '0);
    chk({tag, "_addr"}, RW'(mem_addr_out), '0);
    chk({tag, "_wd"},   mem_wdata_out, '0);
    chk({tag, "_rdy"},  RW'(psum_ready_out), '0);
    chk({tag, "_busy"}, RW'(busy_out), '0);
    chk({tag, "_done"}, RW'(tile_done_out), '0);
    chk({tag, "_ovf"},  RW'(overflow_err_out), '0);
  endtask

  // Runs one tile pass from a negedge; rows[] holds the data to push.
  // rst_at >= 0 aborts the pass with a reset after that many accepted writes.
  task automatic run_pass(input bit first, input int base, input int rdy_pct, input int push_pct,
                          input int stall_at, input int rst_at, output int span, output bit saw_low);
    int sent = 0, wr_n = 0, first_wr = 0, last_wr = -10, last_rd = -10, done_it = -1;
    int overlap = 0, unstable = 0, rd_bad = 0, lat_bad = 0, done_busy = 0;
    bit pend = 0, hold = 0, done_seen = 0, mrdy, vld, stall;
    logic [AW-1:0] paddr = '0;
    logic [AW+RW+1:0] prev = '0, cur;
    exp_t e;
    exp_q.delete();
    saw_low = 0;
    span = 0;
    tile_first_in = first;
    tile_base_in  = AW'(base);
    tile_start_in = 1'b1;
    @(negedge clk);
    tile_start_in = 1'b0;
    chk("busy_set", RW'(busy_out), RW'(1));
    for (int it = 0; it < 5000; it++) begin
      if (rst_at >= 0 && wr_n == rst_at) begin
        rstn = 1'b0; psum_valid_in = 1'b0; mem_ready_in = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_wr", RW'(mem_write_en_out | mem_read_en_out), '0);
        exp_q.delete();
        return;
      end
      mem_rdata_in = pend ? mem[paddr] : '0;
      pend = 0;
      if (tile_done_out) begin
        done_seen = 1; done_it = it;
        if (busy_out) done_busy++;
        psum_valid_in = 1'b0; mem_ready_in = 1'b0;
        @(negedge clk);
        break;
      end
      cur = {mem_read_en_out, mem_write_en_out, mem_addr_out, mem_wdata_out};
      if (mem_read_en_out && mem_write_en_out) overlap++;
      if (hold && cur != prev) unstable++;
      stall = (stall_at >= 0) && (it >= stall_at) && (it < stall_at + 10);
      mrdy  = !stall && ($urandom_range(99) < rdy_pct);
      if (stall && !psum_ready_out) saw_low = 1;
      // a start pulse mid-pass must be ignored
      tile_start_in = (it == 20);
      tile_first_in = (it == 20) ? ~first : first;
      tile_base_in  = (it == 20) ? AW'(999) : AW'(base);
      vld = (sent < ROWS) && psum_ready_out && ($urandom_range(99) < push_pct);
      if (vld) begin
        e.addr = AW'((base + sent) % MEMSZ);
        e.data = first ? rows[sent] : add_row(mem[e.addr], rows[sent]);
        exp_q.push_back(e);
        psum_in = rows[sent];
        sent++;
      end
      if (mem_write_en_out && mrdy) begin
        if (exp_q.size() == 0) chk("wr_unexpected", RW'(1), '0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", RW'(mem_addr_out), RW'(e.addr));
          chk("wr_data", mem_wdata_out, e.data);
        end
        mem[mem_addr_out] = mem_wdata_out;
        if (!first && it - last_rd < 2) lat_bad++;
        if (wr_n == 0) first_wr = it;
        last_wr = it;
        wr_n++;
      end
      if (mem_read_en_out && mrdy) begin
        if (exp_q.size() == 0 || mem_addr_out != exp_q[0].addr) rd_bad++;
        pend = 1; paddr = mem_addr_out; last_rd = it;
      end
      hold = (mem_read_en_out || mem_write_en_out) && !mrdy;
      prev = cur;
      psum_valid_in = vld;
      mem_ready_in  = mrdy;
      @(negedge clk);
    end
    tile_start_in = 1'b0;
    chk("pass_timeout", RW'(done_seen), RW'(1));
    chk("wr_count", RW'(wr_n), RW'(ROWS));
    chk("done_timing", RW'(done_it), RW'(last_wr + 1));
    chk("done_busy_low", RW'(done_busy), '0);
    chk("rw_overlap", RW'(overlap), '0);
    chk("req_stable", RW'(unstable), '0);
    chk("rd_addr", RW'(rd_bad), '0);
    chk("rd_wr_gap", RW'(lat_bad), '0);
    chk("exp_left", RW'(exp_q.size()), '0);
    chk("done_pulse", RW'(tile_done_out), '0);
    chk("busy_clr", RW'(busy_out), '0);
    span = last_wr - first_wr;
  endtask

  initial begin
    int span;
    bit saw;
    for (int a = 0; a < MEMSZ; a++) mem[a] = '0;
    rstn = 1'b0; tile_start_in = 1'b0; tile_first_in = 1'b0; tile_base_in = '0;
    psum_valid_in = 1'b0; psum_in = '0; mem_ready_in = 1'b0; mem_rdata_in = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1: overwrite pass, full rate
    for (int i = 0; i < ROWS; i++) rows[i] = fill(OBW'(i));
    run_pass(1, 0, 100, 100, -1, -1, span, saw);
    chk("t1_rate", RW'(span), RW'(ROWS - 1));
    chk("t1_mem195", mem[195], fill(32'd195));
    chk("t1_ovf", RW'(overflow_err_out), '0);

    // 2: accumulate 5 + 7 with random memory backpressure
    for (int i = 0; i < ROWS; i++) begin mem[300 + i] = fill(32'd5); rows[i] = fill(32'd7); end
    run_pass(0, 300, 60, 70, -1, -1, span, saw);
    chk("t2_mem300", mem[300], fill(32'd12));
    chk("t2_mem495", mem[495], fill(32'd12));
    chk("t2_ovf", RW'(overflow_err_out), '0);

    // 3: ten-cycle memory stall mid-pass
    for (int i = 0; i < ROWS; i++) rows[i] = rnd_row();
    run_pass(1, 100, 100, 100, 30, -1, span, saw);
    chk("t3_ready_drop", RW'(saw), RW'(1));
    chk("t3_ovf", RW'(overflow_err_out), '0);

    // 4: push while not ready -> sticky overflow, row dropped
    psum_valid_in = 1'b1; psum_in = fill(32'hDEAD_BEEF);
    @(negedge clk);
    psum_valid_in = 1'b0;
    chk("t4_ovf_set", RW'(overflow_err_out), RW'(1));
    for (int i = 0; i < ROWS; i++) rows[i] = rnd_row();
    run_pass(1, 600, 70, 70, -1, -1, span, saw);
    chk("t4_ovf_sticky", RW'(overflow_err_out), RW'(1));

    // 5: lane arithmetic edges and address wrap from base 1020
    for (int i = 0; i < ROWS; i++) begin
      mem[(1020 + i) % MEMSZ] = rnd_row();
      rows[i] = rnd_row();
    end
    mem[1020] = fill(32'h7FFF_FFFF); rows[0] = fill(32'h0000_0001);
    mem[1021] = fill(32'h8000_0000); rows[1] = fill(32'hFFFF_FFFF);
    run_pass(0, 1020, 50, 50, -1, -1, span, saw);
`ifdef OUTPUT_SAT_EN
    chk("t5_pos", mem[1020], fill(32'h7FFF_FFFF));
    chk("t5_neg", mem[1021], fill(32'h8000_0000));
`else
    chk("t5_pos", mem[1020], fill(32'h8000_0000));
    chk("t5_neg", mem[1021], fill(32'h7FFF_FFFF));
`endif

    // 6: reset at row 50, then a clean pass
    for (int i = 0; i < ROWS; i++) rows[i] = rnd_row();
    run_pass(1, 40, 100, 80, -1, 50, span, saw);
    for (int i = 0; i < ROWS; i++) rows[i] = rnd_row();
    run_pass(1, 200, 80, 80, -1, -1, span, saw);
    chk("t6_mem200", mem[200], rows[0]);
    chk("t6_ovf", RW'(overflow_err_out), '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
